rc4_prga_decrypt: RTL and testbench

RC4_PRGA_DECRYPT -- requirements
Module: rc4_prga_decrypt

---
 rtl/rc4_prga_decrypt.sv | 166 ++++++++++++++++
 tb/tb_rc4_prga_decrypt.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_prga_decrypt.sv
// RC4 keystream generator (PRGA) with decryption and plaintext screening.
//
// Walks an already key-scheduled S box held in an external RAM. For each
// ciphertext byte k it steps i/j, swaps S[i]/S[j], reads the keystream byte
// S[S[i]+S[j]] and writes (keystream ^ ciphertext) to the plaintext RAM.
// Each byte takes six cycles: RD_I, RD_J, WR_I, WR_J, RD_F, XOR.
// When CHECK_EN is set, the run stops at the first byte outside the accepted
// character set. That byte is still written and is reported in bad_index.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   start                 one-cycle run request, honoured only in IDLE/DONE
//   s_addr/s_wdata/s_wren S RAM port; s_q is read data (1-cycle latency)
//   enc_addr/enc_q        ciphertext ROM port (1-cycle latency)
//   dec_addr/dec_wdata/dec_wren  plaintext RAM write port
//   busy, done            run in progress / run finished (level, held)
//   key_valid, bad_index  run verdict, held in DONE until the next start
module rc4_prga_decrypt #(
    parameter int          MSG_DEP   = 32,
    parameter int          MSG_WIDTH = 8,
    parameter int          CHECK_EN  = 1,
    parameter logic [7:0]  CHAR_LO   = 8'h61,
    parameter logic [7:0]  CHAR_HI   = 8'h7A,
    parameter bit          SPACE_OK  = 1'b1,
    localparam int         AW        = (MSG_DEP > 1) ? $clog2(MSG_DEP) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [MSG_WIDTH-1:0] s_addr,
    output logic [MSG_WIDTH-1:0] s_wdata,
    output logic                 s_wren,
    input  logic [MSG_WIDTH-1:0] s_q,
    output logic [AW-1:0]        enc_addr,
    input  logic [MSG_WIDTH-1:0] enc_q,
    output logic [AW-1:0]        dec_addr,
    output logic [MSG_WIDTH-1:0] dec_wdata,
    output logic                 dec_wren,
    output logic                 busy,
    output logic                 done,
    output logic                 key_valid,
    output logic [AW-1:0]        bad_index
);

    localparam logic [MSG_WIDTH-1:0] LO    = MSG_WIDTH'(CHAR_LO);
    localparam logic [MSG_WIDTH-1:0] HI    = MSG_WIDTH'(CHAR_HI);
    localparam logic [MSG_WIDTH-1:0] SPACE = MSG_WIDTH'(8'h20);
    localparam logic [AW-1:0]        LAST  = AW'(MSG_DEP - 1);

    typedef enum logic [2:0] {
        IDLE, RD_I, RD_J, WR_I, WR_J, RD_F, XOR, DONE
    } state_t;

    state_t               state, state_n;
    logic [MSG_WIDTH-1:0] i, j, si, sj;
    logic [AW-1:0]        k;
    logic [MSG_WIDTH-1:0] pt;
    logic                 char_ok;
    logic                 byte_bad;

    // Plaintext byte is only meaningful in XOR, where s_q holds the
    // keystream read issued in RD_F and enc_q the ciphertext byte.
    assign pt       = s_q ^ enc_q;
    assign char_ok  = ((pt >= LO) && (pt <= HI)) || (SPACE_OK && (pt == SPACE));
    assign byte_bad = (CHECK_EN != 0) && !char_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            si        <= '0;
            sj        <= '0;
            key_valid <= 1'b0;
            bad_index <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        i         <= MSG_WIDTH'(1);
                        j         <= '0;
                        k         <= '0;
                        key_valid <= 1'b0;
                        bad_index <= '0;
                    end
                end
                RD_J: begin
                    si <= s_q;
                    j  <= j + s_q;
                end
                WR_I: sj <= s_q;
                XOR: begin
                    if (byte_bad) begin
                        bad_index <= k;
                        key_valid <= 1'b0;
                    end else if (k == LAST) begin
                        key_valid <= 1'b1;
                    end else begin
                        k <= k + 1'b1;
                        i <= i + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n   = state;
        s_addr    = '0;
        s_wdata   = '0;
        s_wren    = 1'b0;
        enc_addr  = '0;
        dec_addr  = '0;
        dec_wdata = '0;
        dec_wren  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE, DONE: begin
                busy = 1'b0;
                done = (state == DONE);
                if (start) state_n = RD_I;
            end
            RD_I: begin
                s_addr  = i;
                state_n = RD_J;
            end
            RD_J: begin
                // j is not yet updated here, so form the new j directly.
                s_addr  = j + s_q;
                state_n = WR_I;
            end
            WR_I: begin
                // s_q is S[j]; when i == j both writes hit one address and
                // restore the same value.
                s_addr  = i;
                s_wdata = s_q;
                s_wren  = 1'b1;
                state_n = WR_J;
            end
            WR_J: begin
                s_addr  = j;
                s_wdata = si;
                s_wren  = 1'b1;
                state_n = RD_F;
            end
            RD_F: begin
                s_addr   = si + sj;
                enc_addr = k;
                state_n  = XOR;
            end
            XOR: begin
                dec_addr  = k;
                dec_wdata = pt;
                dec_wren  = 1'b1;
                if (byte_bad || (k == LAST)) state_n = DONE;
                else                         state_n = RD_I;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt. Three instances share clock and reset:
//   0: MSG_DEP=4, CHECK_EN=1   1: MSG_DEP=4, CHECK_EN=0   2: MSG_DEP=1, CHECK_EN=1
// A textbook RC4 PRGA model predicts the plaintext writes and verdicts.
// The stimulus side pushes those predictions into per-instance queues, and a
// forked monitor pops and compares them as the DUT writes bytes or raises done.
module tb_rc4_prga_decrypt;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start;
    logic [2:0] init_req;

    logic [7:0] s_addr[3], s_wdata[3], s_q[3], enc_q[3], dec_wdata[3];
    logic [1:0] enc_addr[3], dec_addr[3], bad_index[3];
    logic [2:0] s_wren, dec_wren, busy, done, key_valid;
    logic [0:0] enc_addr_c, dec_addr_c, bad_c;

    logic [7:0] smem[3][256];
    logic [7:0] init_img[256];
    logic [7:0] enc_img[3][4];
    int         cyc = 0;

    typedef struct { int idx; int data; } wr_t;
    typedef struct { int kv; int bad; int lat; } res_t;
    wr_t  exq[3][$];
    res_t res_q[3][$];

    int   ms[3][256];
    int   ks_buf[4];
    int   st_cyc[3];
    int   wr_cnt[3];
    int   exp_kv[3];
    int   exp_n[3];
    logic [7:0] cap[3][4];
    logic [2:0] done_q;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rc4_prga_decrypt #(.MSG_DEP(4), .CHECK_EN(1)) u_a (
        .clk(clk), .reset(rst), .start(start[0]),
        .s_addr(s_addr[0]), .s_wdata(s_wdata[0]), .s_wren(s_wren[0]), .s_q(s_q[0]),
        .enc_addr(enc_addr[0]), .enc_q(enc_q[0]),
        .dec_addr(dec_addr[0]), .dec_wdata(dec_wdata[0]), .dec_wren(dec_wren[0]),
        .busy(busy[0]), .done(done[0]), .key_valid(key_valid[0]), .bad_index(bad_index[0]));

    rc4_prga_decrypt #(.MSG_DEP(4), .CHECK_EN(0)) u_b (
        .clk(clk), .reset(rst), .start(start[1]),
        .s_addr(s_addr[1]), .s_wdata(s_wdata[1]), .s_wren(s_wren[1]), .s_q(s_q[1]),
        .enc_addr(enc_addr[1]), .enc_q(enc_q[1]),
        .dec_addr(dec_addr[1]), .dec_wdata(dec_wdata[1]), .dec_wren(dec_wren[1]),
        .busy(busy[1]), .done(done[1]), .key_valid(key_valid[1]), .bad_index(bad_index[1]));

    rc4_prga_decrypt #(.MSG_DEP(1), .CHECK_EN(1)) u_c (
        .clk(clk), .reset(rst), .start(start[2]),
        .s_addr(s_addr[2]), .s_wdata(s_wdata[2]), .s_wren(s_wren[2]), .s_q(s_q[2]),
        .enc_addr(enc_addr_c), .enc_q(enc_q[2]),
        .dec_addr(dec_addr_c), .dec_wdata(dec_wdata[2]), .dec_wren(dec_wren[2]),
        .busy(busy[2]), .done(done[2]), .key_valid(key_valid[2]), .bad_index(bad_c));

    assign enc_addr[2]  = {1'b0, enc_addr_c};
    assign dec_addr[2]  = {1'b0, dec_addr_c};
    assign bad_index[2] = {1'b0, bad_c};

    // S RAMs and ciphertext ROMs, 1-cycle read latency (read returns old data).
    always @(posedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (init_req[u]) begin
                for (int x = 0; x < 256; x++) smem[u][x] <= init_img[x];
            end else if (s_wren[u]) begin
                smem[u][s_addr[u]] <= s_wdata[u];
            end
            s_q[u]   <= smem[u][s_addr[u]];
            enc_q[u] <= enc_img[u][enc_addr[u]];
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic bit is_ok(input int p);
        return (p >= 'h61 && p <= 'h7a) || p == 'h20;
    endfunction

    // Textbook RC4 PRGA over a copy of init_img; fills ks_buf.
    function automatic void keystream(input int dep);
        int s[256];
        int i, j, t;
        for (int x = 0; x < 256; x++) s[x] = init_img[x];
        i = 0; j = 0;
        for (int n = 0; n < dep; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            ks_buf[n] = s[(s[i] + s[j]) % 256];
        end
    endfunction

    // Predicts the plaintext writes, verdict and latency; permutes ms[u].
    function automatic void model(input int u, input int dep, input bit ce);
        int i, j, t, p, n_done, bad;
        bit fail;
        i = 0; j = 0; n_done = 0; bad = 0; fail = 0;
        for (int n = 0; n < dep && !fail; n++) begin
            i = (i + 1) % 256;
            j = (j + ms[u][i]) % 256;
            t = ms[u][i]; ms[u][i] = ms[u][j]; ms[u][j] = t;
            p = ms[u][(ms[u][i] + ms[u][j]) % 256] ^ int'(enc_img[u][n]);
            exq[u].push_back('{n, p});
            n_done = n + 1;
            if (ce && !is_ok(p)) begin
                fail = 1;
                bad  = n;
            end
        end
        exp_kv[u] = fail ? 0 : 1;
        exp_n[u]  = n_done;
        res_q[u].push_back('{exp_kv[u], bad, 6 * n_done + 1});
    endfunction

    task automatic monitor();
        wr_t  e;
        res_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int u = 0; u < 3; u++) begin
                    if (dec_wren[u]) begin
                        wr_cnt[u]++;
                        cap[u][dec_addr[u]] = dec_wdata[u];
                        if (exq[u].size() == 0) chk("unexpected_write", 1, 0);
                        else begin
                            e = exq[u].pop_front();
                            chk("dec_addr", int'(dec_addr[u]), e.idx);
                            chk("dec_data", int'(dec_wdata[u]), e.data);
                        end
                    end
                    if (done[u] && !done_q[u]) begin
                        if (res_q[u].size() == 0) chk("unexpected_done", 1, 0);
                        else begin
                            r = res_q[u].pop_front();
                            chk("key_valid", int'(key_valid[u]), r.kv);
                            chk("bad_index", int'(bad_index[u]), r.bad);
                            chk("done_latency", cyc - st_cyc[u], r.lat);
                        end
                    end
                end
            end
            done_q = done;
        end
    endtask

    // One run on instance u using init_img as S and enc_img[u] as ciphertext.
    // noise: pulse start during the run. rst_at: assert reset in that cycle.
    task automatic run(input int u, input int dep, input bit ce, input bit noise,
                       input int rst_at);
        int n, mism;
        for (int x = 0; x < 256; x++) ms[u][x] = init_img[x];
        for (int x = 0; x < 4; x++) cap[u][x] = 8'hee;
        @(negedge clk) init_req[u] = 1'b1;
        @(negedge clk) init_req[u] = 1'b0;
        model(u, dep, ce);
        wr_cnt[u] = 0;
        start[u]  = 1'b1;
        st_cyc[u] = cyc;
        @(negedge clk) start[u] = 1'b0;
        chk("busy_after_start", int'(busy[u]), 1);
        chk("kv_cleared", int'(key_valid[u]), 0);
        chk("bad_cleared", int'(bad_index[u]), 0);
        n = cyc - st_cyc[u];
        while (!done[u] && n < 6 * dep + 20) begin
            if (rst_at != 0 && n == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_busy", int'(busy[u]), 0);
                chk("rst_done", int'(done[u]), 0);
                chk("rst_s_wren", int'(s_wren[u]), 0);
                chk("rst_dec_wren", int'(dec_wren[u]), 0);
                @(negedge clk) rst = 1'b0;
                exq[u].delete();
                res_q[u].delete();
                return;
            end
            start[u] = noise && (n == 3 || n == 6 || n == 12 || n == 6 * dep);
            @(negedge clk);
            n = cyc - st_cyc[u];
        end
        start[u] = 1'b0;
        if (!done[u]) begin
            chk("done_timeout", 0, 1);
            return;
        end
        chk("write_count", wr_cnt[u], exp_n[u]);
        mism = 0;
        for (int x = 0; x < 256; x++) if (int'(smem[u][x]) != ms[u][x]) mism++;
        chk("final_S_mismatches", mism, 0);
        repeat (2) @(negedge clk);
        chk("done_held", int'(done[u]), 1);
        chk("busy_low_in_done", int'(busy[u]), 0);
        chk("kv_held", int'(key_valid[u]), exp_kv[u]);
    endtask

    task automatic ident();
        for (int x = 0; x < 256; x++) init_img[x] = 8'(x);
    endtask

    task automatic rand_perm();
        logic [7:0] t;
        int r;
        ident();
        for (int x = 255; x > 0; x--) begin
            r = $urandom_range(x, 0);
            t = init_img[x]; init_img[x] = init_img[r]; init_img[r] = t;
        end
    endtask

    task automatic set_enc(input int u, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
        enc_img[u][0] = a; enc_img[u][1] = b; enc_img[u][2] = c; enc_img[u][3] = d;
    endtask

    task automatic chk_r28(input string tag);
        chk({tag, "_dec0"}, int'(cap[1][0]), 'h02);
        chk({tag, "_dec1"}, int'(cap[1][1]), 'h05);
        chk({tag, "_dec2"}, int'(cap[1][2]), 'h07);
        chk({tag, "_dec3"}, int'(cap[1][3]), 'h0d);
        chk({tag, "_kv"}, int'(key_valid[1]), 1);
        chk({tag, "_S2"}, int'(smem[1][2]), 3);
        chk({tag, "_S3"}, int'(smem[1][3]), 5);
        chk({tag, "_S4"}, int'(smem[1][4]), 9);
        chk({tag, "_S5"}, int'(smem[1][5]), 2);
        chk({tag, "_S9"}, int'(smem[1][9]), 4);
    endtask

    initial begin
        logic [7:0] pt[4];
        int r;
        rst = 1'b1; start = '0; init_req = '0; done_q = '0;
        for (int u = 0; u < 3; u++) set_enc(u, 0, 0, 0, 0);
        ident();
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk("reset_busy", int'(busy[u]), 0);
            chk("reset_done", int'(done[u]), 0);
            chk("reset_kv", int'(key_valid[u]), 0);
            chk("reset_bad", int'(bad_index[u]), 0);
            chk("reset_s_wren", int'(s_wren[u]), 0);
            chk("reset_dec_wren", int'(dec_wren[u]), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Character check: "abcd", then failure on byte 2, then restart.
        ident(); set_enc(0, 8'h63, 8'h67, 8'h64, 8'h69); run(0, 4, 1, 0, 0);
        chk("abcd_0", int'(cap[0][0]), 'h61);
        chk("abcd_3", int'(cap[0][3]), 'h64);
        chk("abcd_kv", int'(key_valid[0]), 1);
        ident(); set_enc(0, 8'h63, 8'h67, 8'h00, 8'h69); run(0, 4, 1, 0, 0);
        chk("fail_byte2", int'(cap[0][2]), 'h07);
        chk("fail_no_byte3", int'(cap[0][3]), 'hee);
        chk("fail_bad", int'(bad_index[0]), 2);
        chk("fail_kv", int'(key_valid[0]), 0);
        ident(); set_enc(0, 8'h63, 8'h67, 8'h64, 8'h69); run(0, 4, 1, 0, 0);

        // No check: zero ciphertext exposes the raw keystream.
        ident(); set_enc(1, 0, 0, 0, 0); run(1, 4, 0, 0, 0); chk_r28("r28");
        ident(); run(1, 4, 0, 1, 0); chk_r28("noise");
        ident(); run(1, 4, 0, 0, 9);
        ident(); run(1, 4, 0, 0, 0); chk_r28("after_rst");

        // Single-byte runs, second one restarted from DONE.
        ident(); set_enc(2, 8'h63, 0, 0, 0); run(2, 1, 1, 0, 0);
        chk("one_pass", int'(cap[2][0]), 'h61);
        ident(); set_enc(2, 8'h00, 0, 0, 0); run(2, 1, 1, 0, 0);
        chk("one_fail", int'(cap[2][0]), 'h02);
        chk("one_fail_kv", int'(key_valid[2]), 0);

        // Random S permutations with mostly-legal plaintext.
        for (int t = 0; t < 12; t++) begin
            rand_perm();
            keystream(4);
            for (int n = 0; n < 4; n++) begin
                r = $urandom_range(26, 0);
                pt[n] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
            end
            if ($urandom_range(1, 0) == 1) pt[$urandom_range(3, 0)] = 8'($urandom_range(31, 0));
            for (int n = 0; n < 4; n++) enc_img[0][n] = pt[n] ^ 8'(ks_buf[n]);
            run(0, 4, 1, 0, 0);
        end
        for (int t = 0; t < 6; t++) begin
            rand_perm();
            for (int n = 0; n < 4; n++) enc_img[1][n] = 8'($urandom);
            run(1, 4, 0, 0, 0);
        end
        for (int t = 0; t < 4; t++) begin
            rand_perm();
            enc_img[2][0] = 8'($urandom);
            run(2, 1, 1, 0, 0);
        end

        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) chk("leftover_expected", exq[u].size() + res_q[u].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
